vertex_assembler: RTL and testbench
===================================

Name: vertex_assembler

Overview:
- Downstream consumer of the vertex transform stage's (Vertex, NewVertex) output; drives that stage's stall input as backpressure.
- Buffers transformed vertices in a small FIFO and groups them into points, lines or triangles.
- Presents each complete primitive to the rasterizer front end over a valid/ready handshake.

Parameters:
DEPTH, 4, vertex FIFO entries (power of two, >= 2)
CNTW, 16, width of the emitted-primitive counter

Ports:
CLK  input  1  single clock, rising edge
RESET_N  input  1  asynchronous active-low reset
Vertex  input  64  transformed vertex {W[63:48], Y[47:32], X[31:16], attr[15:0]}
NewVertex  input  1  Vertex is valid this cycle
stall  output  1  registered backpressure to the transform stage
prim_mode  input  2  0=points, 1=lines, 2=triangles, 3=reserved (treated as points)
flush  input  1  one-cycle pulse: discard the partially gathered primitive
prim_valid  output  1  primitive on prim_v0..v2 is valid
prim_ready  input  1  rasterizer accepts the primitive
prim_v0  output  64  first vertex
prim_v1  output  64  second vertex (zero for points)
prim_v2  output  64  third vertex (zero for points and lines)
prim_size  output  2  vertices in the primitive: 1, 2 or 3
prim_total  output  CNTW  number of primitives accepted by the rasterizer, wraps

Behaviour:
- Reset (RESET_N low, asynchronous): FIFO empty, gather slots cleared, FSM in GATHER.
  - stall=0, prim_valid=0, prim_v0/v1/v2=0, prim_size=0, prim_total=0.
  - Reset asserted mid-primitive discards all buffered and gathered vertices.
- Input acceptance:
  - A vertex is written on a rising edge when NewVertex=1 and stall=0.
  - While stall=1 the producer holds Vertex/NewVertex frozen; a held NewVertex is not accepted again until stall falls, so no vertex is duplicated or lost.
- stall is registered: stall <= (next FIFO occupancy == DEPTH).
  - Writing the last free slot raises stall on the following cycle.
  - A pop that frees a slot drops stall one cycle after the pop.
- FIFO:
  - Occupancy 0..DEPTH; wrap-around read/write pointers.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Pop from empty and push when full never occur by construction.
- Gather FSM:
  - GATHER:
    - Target size N is latched from prim_mode when slot index is 0: points=1, lines=2, triangles=3, reserved=1.
    - When the FIFO is non-empty, pop one vertex per cycle into slot[index] and increment index.
    - When index reaches N, load prim_v0..v2 from the slots (unused outputs zero), set prim_size=N and prim_valid=1, and go to EMIT.
    - Latency: a vertex completing a primitive is visible on prim_v* two cycles after its acceptance edge.
  - EMIT:
    - prim_valid holds and prim_v*/prim_size are stable until prim_ready=1 at a rising edge.
    - On acceptance: prim_valid=0 next cycle, prim_total+1, index=0, back to GATHER.
    - No FIFO pops occur in EMIT; the FIFO keeps accepting until full.
- prim_mode changes mid-primitive are ignored until the next primitive starts.
- flush:
  - In GATHER: index <= 0 and partial slots are discarded. FIFO contents are kept.
  - If a pop coincides with flush, the popped vertex is also discarded.
  - In EMIT: ignored; a presented primitive is never retracted.
- No combinational path from prim_ready or NewVertex to any output.

Test Plan:
- Triangles: reset, prim_mode=2, push X/Y pairs (1,2),(3,4),(5,6) on consecutive cycles with prim_ready=1.
  - Required: one prim_valid pulse, prim_size=3, v0..v2 X fields 1,3,5, prim_total=1.
- Backpressure: prim_mode=1, prim_ready=0, push 8 vertices with NewVertex held high.
  - Required: stall rises after the FIFO holds DEPTH=4 entries plus the 2 gathered vertices.
  - Then raise prim_ready=1. Required: all 8 vertices appear in order as 4 lines, none duplicated, prim_total=4.
- Points and reserved mode: prim_mode=3, push vertex 0x0080_0010_0020_00FF.
  - Required: prim_size=1, prim_v0 equals the pushed vertex, prim_v1=prim_v2=0.
- Flush: prim_mode=2, push 2 vertices, pulse flush, then push 3 more.
  - Required: one triangle containing only the last 3 vertices.
- Async reset in EMIT: with prim_valid=1 and the FIFO holding 3 entries, drop RESET_N mid-cycle.
  - Required: prim_valid, stall and prim_total go to 0 immediately.
  - After release, the next 3 pushed vertices form the first triangle.
- Counter wrap: CNTW=2, emit 5 points. Required: prim_total sequence 1,2,3,0,1.

Source files
------------

// File: rtl/vertex_assembler.sv
// Vertex assembler: buffers transformed vertices in a small FIFO and groups them
// into points, lines or triangles presented to the rasterizer over valid/ready.
module vertex_assembler #(
   parameter int DEPTH = 4,
   parameter int CNTW  = 16
) (
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic [63:0]     Vertex,
   input  logic            NewVertex,
   output logic            stall,
   input  logic [1:0]      prim_mode,
   input  logic            flush,
   output logic            prim_valid,
   input  logic            prim_ready,
   output logic [63:0]     prim_v0,
   output logic [63:0]     prim_v1,
   output logic [63:0]     prim_v2,
   output logic [1:0]      prim_size,
   output logic [CNTW-1:0] prim_total
);

   localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

   typedef enum logic {GATHER = 1'b0, EMIT = 1'b1} state_t;

   logic [63:0]     mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q, count_d;
   logic [63:0]     slot0_q, slot1_q, slot2_q;
   logic [1:0]      idx_q, n_q, target_s;
   state_t          state_q;
   logic            stall_q, valid_q;
   logic [63:0]     v0_q, v1_q, v2_q;
   logic [1:0]      size_q;
   logic [CNTW-1:0] total_q;
   logic            push_s, pop_s;

   function automatic logic [1:0] mode_size(input logic [1:0] mode);
      case (mode)
         2'd1:    mode_size = 2'd2;
         2'd2:    mode_size = 2'd3;
         default: mode_size = 2'd1;
      endcase
   endfunction

   // Handshake decode and next FIFO occupancy; target size is live only before the first slot fills
   always_comb begin
      push_s   = NewVertex && !stall_q;
      target_s = (idx_q == 2'd0) ? mode_size(prim_mode) : n_q;
      pop_s    = (state_q == GATHER) && (count_q != '0) && (idx_q != target_s);
      if (push_s && !pop_s) begin
         count_d = count_q + (AW+1)'(1);
      end else if (pop_s && !push_s) begin
         count_d = count_q - (AW+1)'(1);
      end else begin
         count_d = count_q;
      end
   end

   // FIFO storage needs no reset: occupancy and pointers define validity
   always_ff @(posedge CLK) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= Vertex;
      end
   end

   // FIFO control, gather/emit FSM and registered outputs
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         stall_q  <= 1'b0;
         slot0_q  <= 64'd0;
         slot1_q  <= 64'd0;
         slot2_q  <= 64'd0;
         idx_q    <= 2'd0;
         n_q      <= 2'd1;
         state_q  <= GATHER;
         valid_q  <= 1'b0;
         v0_q     <= 64'd0;
         v1_q     <= 64'd0;
         v2_q     <= 64'd0;
         size_q   <= 2'd0;
         total_q  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
         stall_q <= (count_d == FULL_C);
         case (state_q)
            GATHER: begin
               if (flush) begin
                  // a vertex popped in this cycle is dropped along with the partial slots
                  idx_q <= 2'd0;
               end else if ((idx_q != 2'd0) && (idx_q == n_q)) begin
                  v0_q    <= slot0_q;
                  v1_q    <= (n_q >= 2'd2) ? slot1_q : 64'd0;
                  v2_q    <= (n_q == 2'd3) ? slot2_q : 64'd0;
                  size_q  <= n_q;
                  valid_q <= 1'b1;
                  state_q <= EMIT;
               end else if (pop_s) begin
                  case (idx_q)
                     2'd0:    slot0_q <= mem_q[rd_ptr_q];
                     2'd1:    slot1_q <= mem_q[rd_ptr_q];
                     default: slot2_q <= mem_q[rd_ptr_q];
                  endcase
                  if (idx_q == 2'd0) begin
                     n_q <= target_s;
                  end
                  idx_q <= idx_q + 2'd1;
               end
            end
            EMIT: begin
               if (prim_ready) begin
                  valid_q <= 1'b0;
                  total_q <= total_q + CNTW'(1);
                  idx_q   <= 2'd0;
                  state_q <= GATHER;
               end
            end
            default: begin
               state_q <= GATHER;
            end
         endcase
      end
   end

   assign stall      = stall_q;
   assign prim_valid = valid_q;
   assign prim_v0    = v0_q;
   assign prim_v1    = v1_q;
   assign prim_v2    = v2_q;
   assign prim_size  = size_q;
   assign prim_total = total_q;

endmodule

// File: tb/tb_vertex_assembler.sv
// Bench for vertex_assembler: table-driven cases, a reference gather model feeding
// an expected-primitive queue, and hand-written backpressure/flush/reset/wrap sequences.
module tb_vertex_assembler;

   typedef struct {
      logic [63:0] v0;
      logic [63:0] v1;
      logic [63:0] v2;
      logic [1:0]  size;
   } prim_t;

   typedef struct {
      logic [1:0] mode;
      int         nv;
      int         exp_prims;
   } vec_t;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic [63:0] Vertex;
   logic        NewVertex;
   logic        stall;
   logic [1:0]  prim_mode;
   logic        flush;
   logic        prim_valid;
   logic        prim_ready;
   logic [63:0] prim_v0, prim_v1, prim_v2;
   logic [1:0]  prim_size;
   logic [15:0] prim_total;

   logic [63:0] w_vertex;
   logic        w_new;
   logic        w_stall;
   logic        w_valid;
   logic [63:0] w_v0, w_v1, w_v2;
   logic [1:0]  w_size;
   logic [1:0]  w_total;

   int          checks = 0;
   int          errors = 0;
   prim_t       exp_q[$];
   logic [63:0] pend[$];
   int          pend_n = 1;
   int          acc_cnt = 0;
   int          n_acc = 0;
   logic [15:0] exp_total = 16'd0;
   logic        chk_total = 1'b0;
   logic        prev_v = 1'b0, prev_r = 1'b0;
   logic [63:0] prev_v0 = 64'd0;
   logic [63:0] last_v0, last_v1, last_v2;
   logic [63:0] special;

   vertex_assembler #(.DEPTH(4), .CNTW(16)) u_dut (
      .CLK(CLK), .RESET_N(RESET_N), .Vertex(Vertex), .NewVertex(NewVertex),
      .stall(stall), .prim_mode(prim_mode), .flush(flush), .prim_valid(prim_valid),
      .prim_ready(prim_ready), .prim_v0(prim_v0), .prim_v1(prim_v1), .prim_v2(prim_v2),
      .prim_size(prim_size), .prim_total(prim_total)
   );

   vertex_assembler #(.DEPTH(4), .CNTW(2)) u_wrap (
      .CLK(CLK), .RESET_N(RESET_N), .Vertex(w_vertex), .NewVertex(w_new),
      .stall(w_stall), .prim_mode(2'd0), .flush(1'b0), .prim_valid(w_valid),
      .prim_ready(1'b1), .prim_v0(w_v0), .prim_v1(w_v1), .prim_v2(w_v2),
      .prim_size(w_size), .prim_total(w_total)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic int mode_sz(input logic [1:0] m);
      if (m == 2'd1) return 2;
      if (m == 2'd2) return 3;
      return 1;
   endfunction

   // reference gather model, called on each accepted vertex
   task automatic model_accept(input logic [63:0] v);
      prim_t p;
      if (pend.size() == 0) pend_n = mode_sz(prim_mode);
      pend.push_back(v);
      acc_cnt++;
      if (pend.size() == pend_n) begin
         p.v0   = pend[0];
         p.v1   = (pend_n >= 2) ? pend[1] : 64'd0;
         p.v2   = (pend_n == 3) ? pend[2] : 64'd0;
         p.size = 2'(pend_n);
         exp_q.push_back(p);
         pend.delete();
      end
   endtask

   task automatic push_v(input logic [63:0] v);
      int t;
      t = 0;
      Vertex    = v;
      NewVertex = 1'b1;
      while (stall && t < 200) begin
         @(negedge CLK);
         t++;
      end
      if (t >= 200) begin
         checks++;
         errors++;
         $display("FAIL push_timeout actual=stalled required=accept");
      end
      @(posedge CLK);
      model_accept(v);
      @(negedge CLK);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(negedge CLK);
         t++;
      end
      chk("drain_pending", 64'(exp_q.size()), 64'd0);
      @(negedge CLK);
   endtask

   // scoreboard monitor: outputs sampled on the falling edge
   always @(negedge CLK) begin
      prim_t e;
      if (!RESET_N) begin
         prev_v    = 1'b0;
         prev_r    = 1'b0;
         chk_total = 1'b0;
      end else begin
         if (chk_total) begin
            chk("prim_total", 64'(prim_total), 64'(exp_total));
            chk_total = 1'b0;
         end
         if (prev_v && !prev_r) begin
            chk("hold_valid", 64'(prim_valid), 64'd1);
            chk("hold_v0", prim_v0, prev_v0);
         end
         if (prim_valid && prim_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_prim actual=%h required=none", prim_v0);
            end else begin
               e = exp_q.pop_front();
               chk("prim_v0", prim_v0, e.v0);
               chk("prim_v1", prim_v1, e.v1);
               chk("prim_v2", prim_v2, e.v2);
               chk("prim_size", 64'(prim_size), 64'(e.size));
            end
            last_v0 = prim_v0;
            last_v1 = prim_v1;
            last_v2 = prim_v2;
            n_acc++;
            exp_total = exp_total + 16'd1;
            chk_total = 1'b1;
         end
         prev_v  = prim_valid;
         prev_r  = prim_ready;
         prev_v0 = prim_v0;
      end
   end

   initial begin
      vec_t        tbl[5];
      int          base;
      int          base_acc;
      int          t;
      logic [63:0] v;
      logic [63:0] third;
      logic [1:0]  wrap_exp[5];

      tbl[0] = '{2'd2, 3, 1};
      tbl[1] = '{2'd0, 2, 2};
      tbl[2] = '{2'd1, 4, 2};
      tbl[3] = '{2'd3, 1, 1};
      tbl[4] = '{2'd2, 6, 2};
      wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
      wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
      special = 64'h0080_0010_0020_00FF;

      RESET_N = 1'b0; Vertex = 64'd0; NewVertex = 1'b0; prim_mode = 2'd0;
      flush = 1'b0; prim_ready = 1'b0; w_vertex = 64'd0; w_new = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_valid", 64'(prim_valid), 64'd0);
      chk("rst_v0", prim_v0, 64'd0);
      chk("rst_v2", prim_v2, 64'd0);
      chk("rst_size", 64'(prim_size), 64'd0);
      chk("rst_total", 64'(prim_total), 64'd0);
      chk("rst_wrap_total", 64'(w_total), 64'd0);
      #1 RESET_N = 1'b1;
      @(posedge CLK);
      #1 prim_ready = 1'b1;
      @(negedge CLK);

      for (int c = 0; c < 5; c++) begin
         prim_mode = tbl[c].mode;
         base = n_acc;
         for (int i = 0; i < tbl[c].nv; i++) begin
            if (tbl[c].mode == 2'd3) v = special;
            else v = {16'(c), 16'(2*i+2), 16'(2*i+1), 16'(c*16+i)};
            push_v(v);
         end
         NewVertex = 1'b0;
         drain();
         chk("case_prims", 64'(n_acc - base), 64'(tbl[c].exp_prims));
         if (c == 0) begin
            chk("tri_x0", 64'(last_v0[31:16]), 64'd1);
            chk("tri_x1", 64'(last_v1[31:16]), 64'd3);
            chk("tri_x2", 64'(last_v2[31:16]), 64'd5);
            chk("tri_total", 64'(prim_total), 64'd1);
         end
         if (c == 3) begin
            chk("pt_v0", last_v0, special);
            chk("pt_v1", last_v1, 64'd0);
         end
      end

      // backpressure: lines with the rasterizer stalled
      prim_mode = 2'd1;
      @(posedge CLK);
      #1 prim_ready = 1'b0;
      base = n_acc;
      base_acc = acc_cnt;
      fork
         begin
            for (int i = 0; i < 8; i++) push_v({16'h00BB, 16'(i), 16'(100+i), 16'(i)});
            NewVertex = 1'b0;
         end
         begin
            t = 0;
            while (!stall && t < 100) begin
               @(negedge CLK);
               t++;
            end
            chk("bp_stall_seen", 64'(stall), 64'd1);
            chk("bp_accepted", 64'(acc_cnt - base_acc), 64'd6);
            repeat (4) @(negedge CLK);
            chk("bp_still_stalled", 64'(stall), 64'd1);
            chk("bp_no_dup", 64'(acc_cnt - base_acc), 64'd6);
            @(posedge CLK);
            #1 prim_ready = 1'b1;
         end
      join
      drain();
      chk("bp_lines", 64'(n_acc - base), 64'd4);

      // flush discards the two gathered vertices
      prim_mode = 2'd2;
      base = n_acc;
      push_v({16'h00CC, 16'd1, 16'd1, 16'd1});
      push_v({16'h00CC, 16'd2, 16'd2, 16'd2});
      NewVertex = 1'b0;
      repeat (4) @(negedge CLK);
      flush = 1'b1;
      @(posedge CLK);
      pend.delete();
      @(negedge CLK);
      flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         third = {16'h00DD, 16'(i), 16'(10+i), 16'(i)};
         push_v(third);
      end
      NewVertex = 1'b0;
      drain();
      chk("flush_prims", 64'(n_acc - base), 64'd1);
      chk("flush_v2", last_v2, third);

      // async reset while a triangle is presented and 3 vertices wait in the FIFO
      @(posedge CLK);
      #1 prim_ready = 1'b0;
      for (int i = 0; i < 6; i++) push_v({16'h00EE, 16'(i), 16'(i), 16'(i)});
      NewVertex = 1'b0;
      t = 0;
      while (!prim_valid && t < 20) begin
         @(negedge CLK);
         t++;
      end
      chk("ar_valid_before", 64'(prim_valid), 64'd1);
      @(posedge CLK);
      #2 RESET_N = 1'b0;
      exp_q.delete();
      pend.delete();
      exp_total = 16'd0;
      #1;
      chk("ar_valid", 64'(prim_valid), 64'd0);
      chk("ar_stall", 64'(stall), 64'd0);
      chk("ar_total", 64'(prim_total), 64'd0);
      chk("ar_v0", prim_v0, 64'd0);
      @(negedge CLK);
      #1 RESET_N = 1'b1;
      @(posedge CLK);
      #1 prim_ready = 1'b1;
      @(negedge CLK);
      base = n_acc;
      for (int i = 0; i < 3; i++) push_v({16'h00FF, 16'(i), 16'(50+i), 16'(i)});
      NewVertex = 1'b0;
      drain();
      chk("ar_first_tri", 64'(n_acc - base), 64'd1);
      chk("ar_total_after", 64'(prim_total), 64'd1);

      // 2-bit counter wrap on the second instance
      for (int i = 0; i < 5; i++) begin
         w_vertex = 64'(i);
         w_new = 1'b1;
         @(posedge CLK);
         @(negedge CLK);
         w_new = 1'b0;
         t = 0;
         while (!w_valid && t < 20) begin
            @(negedge CLK);
            t++;
         end
         chk("wrap_valid", 64'(w_valid), 64'd1);
         chk("wrap_v0", w_v0, 64'(i));
         @(negedge CLK);
         chk("wrap_total", 64'(w_total), 64'(wrap_exp[i]));
      end

      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
